// File: rtl/rr_capture_pkg.sv
// Shared types and helpers for the round-robin capture arbiter.
package rr_capture_pkg;

  // Occupancy of the single capture slot.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } cap_state_t;

  // Width of a source-index tag for n requesters; never narrower than one bit.
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_capture_arbiter_pick.sv
// Rotating priority picker: the first set request strictly above last_idx wins,
// otherwise the search wraps to the lowest set request. Purely combinational.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [N-1:0]     upper_mask;
  logic [N-1:0]     upper_req;
  logic [N-1:0]     upper_scan;
  logic [N-1:0]     any_scan;
  logic             upper_found;
  logic             any_found;
  logic [IDX_W-1:0] upper_idx;
  logic [IDX_W-1:0] any_idx;

  // Positions above the last winner form the first search window.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign upper_mask[gi] = (IDX_W'(gi) > last_idx);
  end

  assign upper_req = req & upper_mask;

  // Lowest-set-bit encode of both windows by shifting, so only bit 0 is ever inspected.
  always_comb begin
    upper_scan  = upper_req;
    any_scan    = req;
    upper_found = 1'b0;
    any_found   = 1'b0;
    upper_idx   = '0;
    any_idx     = '0;
    for (int i = 0; i < N; i++) begin
      if (upper_scan[0] && !upper_found) begin
        upper_found = 1'b1;
        upper_idx   = IDX_W'(i);
      end
      if (any_scan[0] && !any_found) begin
        any_found = 1'b1;
        any_idx   = IDX_W'(i);
      end
      upper_scan = upper_scan >> 1;
      any_scan   = any_scan >> 1;
    end
  end

  assign grant_valid = any_found;
  assign grant_idx   = upper_found ? upper_idx : any_idx;

endmodule

// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter feeding one registered capture slot with valid/ready on both sides.
module rr_capture_arbiter
  import rr_capture_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = src_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready
);

  cap_state_t          state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    last_grant_q, last_grant_d;

  logic                grant_valid;
  logic [SRC_W-1:0]    grant_idx;
  logic                can_accept;
  logic                accept;
  logic [NUM_REQ*DATA_W-1:0] data_shift;
  logic [DATA_W-1:0]   grant_data;

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .req         (req_valid),
    .last_idx    (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Reset suppresses handshakes so no producer believes a word was taken during reset.
  assign can_accept = rst_n && ((state_q == EMPTY) || out_ready);
  assign accept     = grant_valid && can_accept;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign data_shift = req_data >> (int'(grant_idx) * DATA_W);
  assign grant_data = data_shift[DATA_W-1:0];

  // Next-state for the slot: refill on accept, drain on out_ready, otherwise hold.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = FULL;
      data_d       = grant_data;
      src_d        = grant_idx;
      last_grant_d = grant_idx;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Capture register, occupancy and round-robin pointer; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      src_q        <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: doc/rr_capture_arbiter.md
Name: rr_capture_arbiter

Overview:
- Shares one registered output slot (a single capture register with synchronous active-low reset) between NUM_REQ requesters.
- Uses round-robin arbitration and valid/ready handshakes on both sides.
- Sits between several producer blocks and one downstream consumer. The consumer receives exactly one captured word at a time, tagged with its source index.

Parameters:
- NUM_REQ, 4, number of requesters (≥1).
- DATA_W, 8, payload width per requester.
- SRC_W, $clog2(NUM_REQ) (min 1), width of the source-index tag.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- out_valid  output  1  capture slot holds a word.
- out_data  output  DATA_W  captured payload.
- out_src  output  SRC_W  index of the requester whose word is in the slot.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, out_src=0.
  - State=EMPTY.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Any word held in the slot is discarded.
  - Reset wins over every other event in the same cycle.
- State machine (2 states):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and no new accept.
  - FULL -> FULL when out_ready=0 (hold), or when out_ready=1 together with a new accept (drain and refill).
- can_accept = (state==EMPTY) | out_ready. This is combinational; a drain and a refill in the same cycle are allowed, giving full throughput of 1 word/cycle.
- Grant selection (combinational):
  - Search req_valid starting at index (last_grant+1) mod NUM_REQ and wrap upward.
  - The first set bit is g.
  - No valid request -> no grant.
- req_ready[g]=1 only when a grant exists and can_accept=1. All other req_ready bits are 0.
  - req_ready may depend combinationally on req_valid and out_ready.
  - req_valid must never depend on req_ready.
- Accept (req_valid[g] & req_ready[g]): at the next edge out_data<=req_data[g], out_src<=g, out_valid<=1, last_grant<=g.
  - Latency is 1 cycle from accept to out_valid.
- last_grant changes only on accept. Idle cycles and stall cycles leave it unchanged.
- While out_valid=1 and out_ready=0: out_data and out_src are stable, and req_ready is all-zero.
- A requester may drop req_valid without being granted. No lock-in; arbitration re-evaluates each cycle.
- NUM_REQ=1: degenerates to a registered valid/ready slot; out_src is always 0.
- out_ready while EMPTY is ignored.
- No combinational path from req_* to out_valid, out_data or out_src.

Decomposition:
- Package rr_capture_pkg:
  - state typedef enum {EMPTY, FULL};
  - function src_width(n) returning max(1, $clog2(n)).
- Sub-module rr_priority_pick (parameters N, IDX_W):
  - Inputs: req vector and last index.
  - Outputs: grant_valid and grant_idx.
  - Purely combinational rotate-and-priority-encode, reusable by other arbiters.
- The top level holds the FSM, the capture register and the last_grant register.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0, out_src=0. After release, the first grant is req 0.
2. Round-robin fairness: req_valid=4'b1111 constant, out_ready=1, data_i=8'hA0+i -> out_src sequence 0,1,2,3,0 and out_data A0,A1,A2,A3,A0. One word per cycle, no bubbles.
3. Backpressure: slot FULL with out_src=2 and data 8'h5C, out_ready=0 for 5 cycles, req_valid=4'b1011 -> out_data/out_src held, req_ready=0 throughout. On out_ready=1, the next grant is req 3 in the same cycle, then req 0.
4. Sparse and wrap-around: last_grant=3, only req_valid[1]=1 -> grant 1, out_src=1 one cycle later. Then only req 0 valid -> grant 0 (wrap search).
5. Reset mid-operation: FULL with data 8'hFF, assert rst_n=0 for one cycle while req 2 is valid and out_ready=1 -> next cycle out_valid=0 and no word is consumed. After release, priority restarts at req 0.
6. Request withdrawal: req 1 valid for 1 cycle while the slot is stalled, then dropped -> req 1 is never captured and the next grant goes to the next valid requester.
